// File: rtl/lab3_cache_mem_arbiter.sv
// Two-requester arbiter sharing one memory port, one transaction in flight.
// Requests and responses are latched whole and forwarded unmodified.
module lab3_cache_mem_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_val,
    output logic        req0_rdy,
    input  logic [76:0] req0_msg,
    output logic        resp0_val,
    input  logic        resp0_rdy,
    output logic [46:0] resp0_msg,

    input  logic        req1_val,
    output logic        req1_rdy,
    input  logic [76:0] req1_msg,
    output logic        resp1_val,
    input  logic        resp1_rdy,
    output logic [46:0] resp1_msg,

    output logic        mem_req_val,
    input  logic        mem_req_rdy,
    output logic [76:0] mem_req_msg,
    input  logic        mem_resp_val,
    output logic        mem_resp_rdy,
    input  logic [46:0] mem_resp_msg
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        prio_q,  prio_d;
    logic [76:0] req_q,   req_d;
    logic [46:0] resp_q,  resp_d;
    logic        grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            req_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            req_q   <= req_d;
            resp_q  <= resp_d;
        end
    end

    // Sole valid requester wins; on contention the priority bit decides.
    assign grant = (req0_val && req1_val) ? prio_q : req1_val;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        prio_d       = prio_q;
        req_d        = req_q;
        resp_d       = resp_q;
        req0_rdy     = 1'b0;
        req1_rdy     = 1'b0;
        mem_req_val  = 1'b0;
        mem_resp_rdy = 1'b0;
        resp0_val    = 1'b0;
        resp1_val    = 1'b0;
        unique case (state_q)
            IDLE: begin
                req0_rdy = req0_val && !grant;
                req1_rdy = req1_val && grant;
                if (req0_val || req1_val) begin
                    state_d = SEND;
                    owner_d = grant;
                    prio_d  = !grant;
                    req_d   = grant ? req1_msg : req0_msg;
                end
            end
            SEND: begin
                mem_req_val = 1'b1;
                if (mem_req_rdy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                mem_resp_rdy = 1'b1;
                if (mem_resp_val) begin
                    state_d = RESP;
                    resp_d  = mem_resp_msg;
                end
            end
            RESP: begin
                resp0_val = !owner_q;
                resp1_val = owner_q;
                if (owner_q ? resp1_rdy : resp0_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req_msg = req_q;
    assign resp0_msg   = resp_q;
    assign resp1_msg   = resp_q;

endmodule

// File: tb/tb_lab3_cache_mem_arbiter.sv
// Directed and randomized checks for lab3_cache_mem_arbiter.
// Requests: {type,opaque,addr,len,data}; responses: {type,opaque,test,len,data}.
module tb_lab3_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_val, req0_rdy, resp0_val, resp0_rdy;
    logic        req1_val, req1_rdy, resp1_val, resp1_rdy;
    logic        mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
    logic [76:0] req0_msg, req1_msg, mem_req_msg;
    logic [46:0] resp0_msg, resp1_msg, mem_resp_msg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lab3_cache_mem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req0_val     (req0_val),
        .req0_rdy     (req0_rdy),
        .req0_msg     (req0_msg),
        .resp0_val    (resp0_val),
        .resp0_rdy    (resp0_rdy),
        .resp0_msg    (resp0_msg),
        .req1_val     (req1_val),
        .req1_rdy     (req1_rdy),
        .req1_msg     (req1_msg),
        .resp1_val    (resp1_val),
        .resp1_rdy    (resp1_rdy),
        .resp1_msg    (resp1_msg),
        .mem_req_val  (mem_req_val),
        .mem_req_rdy  (mem_req_rdy),
        .mem_req_msg  (mem_req_msg),
        .mem_resp_val (mem_resp_val),
        .mem_resp_rdy (mem_resp_rdy),
        .mem_resp_msg (mem_resp_msg)
    );

    function automatic logic [76:0] mkreq(input logic [2:0] t, input logic [7:0] op,
                                          input logic [31:0] addr, input logic [31:0] data);
        return {t, op, addr, 2'b00, data};
    endfunction

    function automatic logic [46:0] mkresp(input logic [2:0] t, input logic [7:0] op,
                                           input logic [31:0] data);
        return {t, op, 2'b00, 2'b00, data};
    endfunction

    // Reference memory: read data derived from address and write data.
    function automatic logic [46:0] memresp(input logic [76:0] r);
        return mkresp(r[76:74], r[73:66], r[65:34] ^ 32'hFFFF0000 ^ r[31:0]);
    endfunction

    task automatic chk(input string tag, input logic [76:0] obs, input logic [76:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    logic [76:0] r0, r1, rb;
    logic [46:0] p0, p1, pb;
    bit          g;
    bit          exp_grant [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    logic [46:0] q0[$];
    logic [46:0] q1[$];
    int          seq0, seq1, acc0, acc1;
    bit          mprio, mpend, w, drain;
    logic [76:0] mlast;
    logic [46:0] mpresp;

    initial begin
        reset        = 1'b1;
        req0_val     = 1'b0;
        req1_val     = 1'b0;
        req0_msg     = '0;
        req1_msg     = '0;
        resp0_rdy    = 1'b0;
        resp1_rdy    = 1'b0;
        mem_req_rdy  = 1'b0;
        mem_resp_val = 1'b0;
        mem_resp_msg = '0;

        // Reset state
        reset_dut();
        #1;
        chk("rst_mreq_val",  mem_req_val,  0);
        chk("rst_mresp_rdy", mem_resp_rdy, 0);
        chk("rst_resp0_val", resp0_val,    0);
        chk("rst_resp1_val", resp1_val,    0);
        chk("rst_req0_rdy",  req0_rdy,     0);
        chk("rst_req1_rdy",  req1_rdy,     0);

        // Single read, zero memory delay
        r0 = mkreq(3'd0, 8'h5A, 32'h00001000, 32'h0);
        p0 = mkresp(3'd0, 8'h5A, 32'hDEADBEEF);
        cyc();
        req0_val = 1'b1;
        req0_msg = r0;
        #1;
        chk("sr_req0_rdy", req0_rdy, 1);
        chk("sr_req1_rdy", req1_rdy, 0);
        cyc();
        req0_val    = 1'b0;
        mem_req_rdy = 1'b1;
        #1;
        chk("sr_mreq_val", mem_req_val, 1);
        chk("sr_mreq_msg", mem_req_msg, r0);
        chk("sr_send_rdy", req0_rdy, 0);
        cyc();
        mem_req_rdy  = 1'b0;
        mem_resp_val = 1'b1;
        mem_resp_msg = p0;
        #1;
        chk("sr_wait_mreq", mem_req_val, 0);
        chk("sr_mresp_rdy", mem_resp_rdy, 1);
        cyc();
        mem_resp_val = 1'b0;
        resp0_rdy    = 1'b1;
        #1;
        chk("sr_resp0_val", resp0_val, 1);
        chk("sr_resp1_val", resp1_val, 0);
        chk("sr_resp0_msg", resp0_msg, p0);
        chk("sr_opaque",    resp0_msg[43:36], 8'h5A);
        chk("sr_data",      resp0_msg[31:0], 32'hDEADBEEF);
        cyc();
        resp0_rdy = 1'b0;
        req0_val  = 1'b1;
        #1;
        chk("sr_T4_rdy",  req0_rdy, 1);
        chk("sr_T4_resp", resp0_val, 0);
        req0_val = 1'b0;

        // Contention from reset: grants alternate 0,1,0,1
        reset_dut();
        r0 = mkreq(3'd0, 8'h01, 32'h00000100, 32'h0);
        r1 = mkreq(3'd1, 8'h02, 32'h00000200, 32'h00001234);
        p0 = mkresp(3'd0, 8'h01, 32'h11110000);
        p1 = mkresp(3'd1, 8'h02, 32'h22220000);
        req0_val    = 1'b1;
        req1_val    = 1'b1;
        req0_msg    = r0;
        req1_msg    = r1;
        mem_req_rdy = 1'b1;
        resp0_rdy   = 1'b1;
        resp1_rdy   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            g = exp_grant[i];
            #1;
            chk("ct_rdy0", req0_rdy, !g);
            chk("ct_rdy1", req1_rdy, g);
            cyc();
            #1;
            chk("ct_mreq_msg", mem_req_msg, g ? r1 : r0);
            chk("ct_send_rdy", req0_rdy | req1_rdy, 0);
            cyc();
            mem_resp_val = 1'b1;
            mem_resp_msg = g ? p1 : p0;
            #1;
            chk("ct_mresp_rdy", mem_resp_rdy, 1);
            cyc();
            mem_resp_val = 1'b0;
            #1;
            chk("ct_resp0_val", resp0_val, !g);
            chk("ct_resp1_val", resp1_val, g);
            chk("ct_resp_msg",  g ? resp1_msg : resp0_msg, g ? p1 : p0);
            cyc();
        end

        // Memory back-pressure on a req1 transaction, then response back-pressure
        rb = mkreq(3'd1, 8'h33, 32'h00003000, 32'hCAFEF00D);
        pb = mkresp(3'd0, 8'h33, 32'h0BADF00D);
        r0 = mkreq(3'd0, 8'h44, 32'h00004000, 32'h0);
        req0_val    = 1'b0;
        req1_val    = 1'b1;
        req1_msg    = rb;
        req0_msg    = r0;
        mem_req_rdy = 1'b0;
        resp1_rdy   = 1'b0;
        #1;
        chk("bp_req1_rdy", req1_rdy, 1);
        chk("bp_req0_rdy", req0_rdy, 0);
        cyc();
        req1_val = 1'b0;
        req0_val = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_mreq_val", mem_req_val, 1);
            chk("bp_mreq_msg", mem_req_msg, rb);
            chk("bp_req_rdy",  req0_rdy | req1_rdy, 0);
            cyc();
        end
        mem_req_rdy = 1'b1;
        #1;
        chk("bp_mreq_fire", mem_req_val, 1);
        cyc();
        mem_req_rdy  = 1'b0;
        mem_resp_val = 1'b1;
        mem_resp_msg = pb;
        #1;
        chk("bp_mresp_rdy", mem_resp_rdy, 1);
        cyc();
        mem_resp_val = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rbp_resp1_val", resp1_val, 1);
            chk("rbp_resp1_msg", resp1_msg, pb);
            chk("rbp_resp0_val", resp0_val, 0);
            chk("rbp_mresp_rdy", mem_resp_rdy, 0);
            chk("rbp_req0_rdy",  req0_rdy, 0);
            cyc();
        end
        resp1_rdy = 1'b1;
        #1;
        chk("rbp_fire_val", resp1_val, 1);
        cyc();
        #1;
        chk("rbp_req0_acc", req0_rdy, 1);
        chk("rbp_resp1_off", resp1_val, 0);

        // req0 accepted above; reset while waiting on memory
        cyc();
        req0_val    = 1'b0;
        mem_req_rdy = 1'b1;
        #1;
        chk("rw_mreq_msg", mem_req_msg, r0);
        cyc();
        mem_req_rdy = 1'b0;
        reset       = 1'b1;
        #1;
        chk("rw_wait_rdy", mem_resp_rdy, 1);
        cyc();
        reset        = 1'b0;
        mem_resp_val = 1'b1;
        mem_resp_msg = mkresp(3'd0, 8'hEE, 32'hBAADBAAD);
        #1;
        chk("rw_stray_rdy", mem_resp_rdy, 0);
        chk("rw_resp_val",  resp0_val | resp1_val, 0);
        chk("rw_mreq_val",  mem_req_val, 0);
        cyc();
        mem_resp_val = 1'b0;
        req0_val     = 1'b1;
        req1_val     = 1'b1;
        #1;
        chk("rw_no_resp", resp0_val | resp1_val, 0);
        chk("rw_prio0",   req0_rdy, 1);
        chk("rw_prio1",   req1_rdy, 0);
        req1_val = 1'b0;
        cyc();
        req0_val    = 1'b0;
        mem_req_rdy = 1'b1;
        #1;
        chk("rw2_mreq_msg", mem_req_msg, r0);
        cyc();
        mem_req_rdy  = 1'b0;
        mem_resp_val = 1'b1;
        mem_resp_msg = memresp(r0);
        cyc();
        mem_resp_val = 1'b0;
        resp0_rdy    = 1'b1;
        #1;
        chk("rw2_resp0_val", resp0_val, 1);
        chk("rw2_resp0_msg", resp0_msg, memresp(r0));
        cyc();

        // Reset overrides an accept in the same cycle
        req0_val = 1'b1;
        reset    = 1'b1;
        cyc();
        reset    = 1'b0;
        req0_val = 1'b0;
        #1;
        chk("ro_mreq_val", mem_req_val, 0);

        // Random val/rdy traffic against a scoreboard
        reset_dut();
        seq0  = 0;
        seq1  = 0;
        acc0  = 0;
        acc1  = 0;
        mprio = 1'b0;
        mpend = 1'b0;
        mlast = '0;
        mpresp = '0;
        for (int c = 0; c < 600; c++) begin
            drain    = (c >= 500);
            req0_msg = mkreq(3'd0, {1'b0, seq0[6:0]}, 32'h2000 + 32'(seq0) * 4, 32'h0);
            req1_msg = mkreq(3'd1, {1'b1, seq1[6:0]}, 32'h8000 + 32'(seq1) * 4,
                             32'(seq1) * 32'h01010101);
            req0_val    = !drain && ($urandom_range(0, 2) != 0);
            req1_val    = !drain && ($urandom_range(0, 2) != 0);
            mem_req_rdy = drain || ($urandom_range(0, 1) != 0);
            resp0_rdy   = drain || ($urandom_range(0, 1) != 0);
            resp1_rdy   = drain || ($urandom_range(0, 1) != 0);
            if (mpend) begin
                mem_resp_val = drain || ($urandom_range(0, 2) == 0);
                mem_resp_msg = mpresp;
            end else begin
                mem_resp_val = !drain && ($urandom_range(0, 4) == 0);
                mem_resp_msg = 47'($urandom);
            end
            #1;
            chk("rnd_rdy_excl",  req0_rdy & req1_rdy, 0);
            chk("rnd_resp_excl", resp0_val & resp1_val, 0);
            if ((req0_val && req0_rdy) || (req1_val && req1_rdy)) begin
                w = (req0_val && req1_val) ? mprio : req1_val;
                g = req1_val && req1_rdy;
                chk("rnd_grant", g, w);
                mlast = g ? req1_msg : req0_msg;
                if (g) begin
                    q1.push_back(memresp(mlast));
                    seq1++;
                    acc1++;
                end else begin
                    q0.push_back(memresp(mlast));
                    seq0++;
                    acc0++;
                end
                mprio = !g;
            end
            if (mem_req_val && mem_req_rdy) begin
                chk("rnd_mreq_msg", mem_req_msg, mlast);
                mpend  = 1'b1;
                mpresp = memresp(mlast);
            end
            if (mem_resp_val && mem_resp_rdy) begin
                chk("rnd_mresp_pend", mpend, 1);
                mpend = 1'b0;
            end
            if (resp0_val && resp0_rdy) begin
                chk("rnd_q0_nonempty", q0.size() > 0, 1);
                if (q0.size() > 0) chk("rnd_resp0_msg", resp0_msg, q0.pop_front());
            end
            if (resp1_val && resp1_rdy) begin
                chk("rnd_q1_nonempty", q1.size() > 0, 1);
                if (q1.size() > 0) chk("rnd_resp1_msg", resp1_msg, q1.pop_front());
            end
            cyc();
        end
        chk("rnd_q0_drained", q0.size(), 0);
        chk("rnd_q1_drained", q1.size(), 0);
        chk("rnd_mem_idle",   mpend, 0);
        chk("rnd_acc0_seen",  acc0 > 0, 1);
        chk("rnd_acc1_seen",  acc1 > 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
